onewire_ds18b20_slave: RTL

ONEWIRE_DS18B20_SLAVE -- requirements
Module: onewire_ds18b20_slave

---
 rtl/onewire_pkg.sv | 59 +++++
 rtl/onewire_crc8.sv | 34 +++
 rtl/onewire_ds18b20_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: FSM state encoding, DS18B20 command codes,
// fixed scratchpad contents and slot timings (in microseconds).
//
// Helper sp_byte() maps a scratchpad index (0..8) to the byte value,
// given the latched temperature and the running CRC.
package onewire_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        PRES_WAIT,
        PRES_DRIVE,
        ROM_CMD,
        FUNC_CMD,
        TX_DATA,
        SKIP
    } state_t;

    // Command codes
    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ_SP  = 8'hBE;

    // Fixed scratchpad bytes 2..7 and the power-on temperature (+85 C)
    localparam logic [7:0]  SP_TH     = 8'h4B;
    localparam logic [7:0]  SP_TL     = 8'h46;
    localparam logic [7:0]  SP_CFG    = 8'h7F;
    localparam logic [7:0]  SP_RES0   = 8'hFF;
    localparam logic [7:0]  SP_RES1   = 8'h0C;
    localparam logic [7:0]  SP_RES2   = 8'h10;
    localparam logic [15:0] TEMP_POR  = 16'h0550;

    // Slot timings in microseconds
    localparam int PRES_WAIT_US = 30;   // rising edge of reset -> presence start
    localparam int PRES_LOW_US  = 120;  // presence pulse width
    localparam int SAMPLE_US    = 30;   // falling edge -> write-slot sample point
    localparam int TX0_US       = 30;   // hold time for a transmitted 0
    localparam int SLOT_US      = 45;   // window in which further falls are ignored

    function automatic logic [7:0] sp_byte(input logic [3:0]  idx,
                                           input logic [15:0] temp,
                                           input logic [7:0]  crc);
        logic [7:0] b;
        case (idx)
            4'd0:    b = temp[7:0];
            4'd1:    b = temp[15:8];
            4'd2:    b = SP_TH;
            4'd3:    b = SP_TL;
            4'd4:    b = SP_CFG;
            4'd5:    b = SP_RES0;
            4'd6:    b = SP_RES1;
            4'd7:    b = SP_RES2;
            4'd8:    b = crc;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Bitwise-serial Dallas/Maxim CRC-8 (x^8 + x^5 + x^4 + 1, init 0),
// data bits presented LSB first.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (priority over en)
//   en         : shift one data bit in
//   din        : data bit
//   crc        : current CRC value
module onewire_crc8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[0] ^ din;

    // Reflected form: shift right, fold feedback in with 0x8C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {fb, crc[7:1]} ^ {4'b0000, fb, fb, 2'b00};
        end
    end

endmodule

// File: rtl/onewire_ds18b20_slave.sv
// DS18B20-style 1-Wire slave: answers bus reset with a presence pulse,
// accepts Skip ROM followed by Convert T or Read Scratchpad, and serves
// the 9-byte scratchpad (CRC computed on the fly while bytes 0-7 go out).
//
// Ports:
//   CLK_10MHZ     : system clock (CLK_PER_US cycles per microsecond)
//   rst_n         : asynchronous active-low reset
//   oneWirePin    : open-drain bus, driven 0 or released
//   temp_in       : temperature sampled on Convert T
//   cmd_valid     : one-cycle pulse per received command byte
//   cmd_byte      : last received command byte
//   presence_sent : one-cycle pulse at end of presence pulse
//   busy          : FSM not in IDLE
module onewire_ds18b20_slave
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US = 10,
    parameter int RST_MIN_US = 400
) (
    input  logic        CLK_10MHZ,
    input  logic        rst_n,
    inout  wire         oneWirePin,
    input  logic [15:0] temp_in,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        presence_sent,
    output logic        busy
);

    localparam int RST_CYC = RST_MIN_US * CLK_PER_US;
    localparam int LOW_W   = $clog2(RST_CYC + 1);
    localparam int TMR_W   = $clog2(PRES_LOW_US * CLK_PER_US + 1);

    localparam logic [LOW_W-1:0] RST_LAST   = LOW_W'(RST_CYC - 1);
    localparam logic [LOW_W-1:0] RST_SAT    = LOW_W'(RST_CYC);
    localparam logic [TMR_W-1:0] PW_LAST    = TMR_W'(PRES_WAIT_US * CLK_PER_US - 1);
    localparam logic [TMR_W-1:0] PL_LAST    = TMR_W'(PRES_LOW_US * CLK_PER_US - 1);
    localparam logic [TMR_W-1:0] SMP_LAST   = TMR_W'(SAMPLE_US * CLK_PER_US - 1);
    localparam logic [TMR_W-1:0] TX0_LAST   = TMR_W'(TX0_US * CLK_PER_US - 1);
    localparam logic [TMR_W-1:0] SLOT_LAST  = TMR_W'(SLOT_US * CLK_PER_US - 1);

    state_t            state, state_next;
    logic              rst_meta, run;
    logic              pin_s1, pin_s2, pin_prev;
    logic              drive_low;
    logic [LOW_W-1:0]  low_cnt;
    logic [TMR_W-1:0]  timer;
    logic              slot_active;
    logic [2:0]        bit_cnt;
    logic [3:0]        byte_idx;
    logic [7:0]        shift;
    logic [15:0]       temp_q;
    logic [7:0]        crc;
    logic              crc_clr, crc_en;

    logic              fall, rise, rst_det;
    logic              rx_state, slot_start, sample_pt, slot_end, byte_done, tx_last;
    logic [7:0]        rx_byte, tx_byte;
    logic              tx_bit;

    // The only driver of the bus
    assign oneWirePin = drive_low ? 1'b0 : 1'bz;
    assign busy       = (state != IDLE);

    // Reset deassertion synchroniser; the bus watcher stays idle until run
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 1'b0;
            run      <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            run      <= rst_meta;
        end
    end

    // Bus synchroniser and edge history (idle bus reads high)
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            pin_s1   <= 1'b1;
            pin_s2   <= 1'b1;
            pin_prev <= 1'b1;
        end else begin
            pin_s1   <= oneWirePin;
            pin_s2   <= pin_s1;
            pin_prev <= pin_s2;
        end
    end

    assign fall = pin_prev & ~pin_s2;
    assign rise = ~pin_prev & pin_s2;

    // Low-time counter; our own drive never counts toward a bus reset
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt <= '0;
        end else if (!run || drive_low || pin_s2) begin
            low_cnt <= '0;
        end else if (low_cnt != RST_SAT) begin
            low_cnt <= low_cnt + 1'b1;
        end
    end

    // Fires exactly once per long low, on the cycle the threshold is reached
    assign rst_det = run & ~drive_low & ~pin_s2 & (low_cnt == RST_LAST);

    assign rx_state   = (state == ROM_CMD) || (state == FUNC_CMD);
    assign slot_start = (rx_state || state == TX_DATA) && fall && !slot_active && !drive_low;
    assign sample_pt  = rx_state && slot_active && (timer == SMP_LAST);
    assign slot_end   = slot_active && (timer == SLOT_LAST);
    assign rx_byte    = {pin_s2, shift[7:1]};
    assign byte_done  = sample_pt && (bit_cnt == 3'd7);
    assign tx_byte    = sp_byte(byte_idx, temp_q, crc);
    assign tx_bit     = tx_byte[bit_cnt];
    assign tx_last    = (state == TX_DATA) && slot_end && (byte_idx == 4'd8) && (bit_cnt == 3'd7);
    // CRC byte itself is sent from a frozen accumulator
    assign crc_en     = (state == TX_DATA) && slot_start && (byte_idx != 4'd8);

    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        crc_clr    = 1'b0;
        case (state)
            IDLE:       state_next = IDLE;
            RST_LOW:    if (rise) state_next = PRES_WAIT;
            PRES_WAIT:  if (timer == PW_LAST) state_next = PRES_DRIVE;
            PRES_DRIVE: if (timer == PL_LAST) state_next = ROM_CMD;
            ROM_CMD: begin
                if (byte_done) begin
                    state_next = (rx_byte == CMD_SKIP_ROM) ? FUNC_CMD : SKIP;
                end
            end
            FUNC_CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_CONVERT) begin
                        state_next = IDLE;
                    end else if (rx_byte == CMD_READ_SP) begin
                        state_next = TX_DATA;
                        crc_clr    = 1'b1;
                    end else begin
                        state_next = SKIP;
                    end
                end
            end
            TX_DATA:    if (tx_last) state_next = IDLE;
            SKIP:       state_next = SKIP;
            default:    state_next = IDLE;
        endcase
        if (rst_det) begin
            state_next = RST_LOW;
        end
    end

    // Timers, slot tracking, drive control, shift/transmit counters
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            timer         <= '0;
            slot_active   <= 1'b0;
            drive_low     <= 1'b0;
            bit_cnt       <= 3'd0;
            byte_idx      <= 4'd0;
            shift         <= 8'h00;
            cmd_valid     <= 1'b0;
            cmd_byte      <= 8'h00;
            presence_sent <= 1'b0;
            temp_q        <= TEMP_POR;
        end else begin
            cmd_valid     <= 1'b0;
            presence_sent <= 1'b0;

            if (state_next != state) begin
                timer       <= '0;
                slot_active <= 1'b0;
            end else if (slot_start) begin
                timer       <= '0;
                slot_active <= 1'b1;
            end else begin
                if (slot_end) begin
                    slot_active <= 1'b0;
                end
                if (state == PRES_WAIT || state == PRES_DRIVE || slot_active) begin
                    timer <= timer + 1'b1;
                end
            end

            if (rst_det) begin
                drive_low <= 1'b0;
            end else if (state == PRES_WAIT && state_next == PRES_DRIVE) begin
                drive_low <= 1'b1;
            end else if (state == PRES_DRIVE && state_next == ROM_CMD) begin
                drive_low     <= 1'b0;
                presence_sent <= 1'b1;
            end else if (state == TX_DATA && slot_start && !tx_bit) begin
                drive_low <= 1'b1;
            end else if (state == TX_DATA && slot_active && timer == TX0_LAST) begin
                drive_low <= 1'b0;
            end

            if (rst_det) begin
                bit_cnt  <= 3'd0;
                byte_idx <= 4'd0;
            end else if (sample_pt) begin
                shift   <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= rx_byte;
                    if (state_next == TX_DATA) begin
                        byte_idx <= 4'd0;
                    end
                    if (state == FUNC_CMD && rx_byte == CMD_CONVERT) begin
                        temp_q <= temp_in;
                    end
                end
            end else if (state == TX_DATA && slot_end) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_idx <= byte_idx + 4'd1;
                end
            end
        end
    end

    onewire_crc8 u_crc (
        .clk   (CLK_10MHZ),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (tx_bit),
        .crc   (crc)
    );

endmodule
